fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It owns the PC and drives the instruction memory through a variable-latency request/valid handshake. It presents the fetched word combinationally to hazard detection, then registers it into ID. It honours load-use stalls, squashes on taken branches resolved in ID, and stops fetching after an HLT.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and
// the instruction memory. The fetch side holds the address steady until the
// memory raises valid for it.
interface fetch_stage_if;
    logic        req;
    logic [15:0] addr;
    logic [15:0] data;
    logic        valid;

    // Fetch stage: issues requests and consumes same-cycle responses.
    modport master (
        output req,
        output addr,
        input  data,
        input  valid
    );

    // Instruction memory: answers the presented address when it is ready.
    modport slave (
        input  req,
        input  addr,
        output data,
        output valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the 16-bit CPU.
// Owns the PC and fetches over a variable-latency req/valid channel. Handles
// load-use stalls, squashes on branches resolved in ID, drains an outstanding
// fetch before redirecting, and stops fetching once an HLT has been fetched.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [15:0]          branch_target,
    fetch_stage_if.master        imem,
    output logic [15:0]          instr_IF,
    output logic [15:0]          instr_ID,
    output logic [15:0]          pc_plus2_ID,
    output logic                 valid_ID,
    output logic                 fetch_halted
);

    // FETCH  : normal fetching, one instruction per accepted response.
    // DRAIN  : a branch arrived while a fetch was outstanding; wait for the
    //          stale response so the address never changes mid-request.
    // HALTED : an HLT was fetched; no further requests until redirected.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] redirect_pc;
    logic [15:0] pc_plus2;
    logic        fetched_hlt;

    assign pc_plus2    = pc + 16'd2;
    assign fetched_hlt = (imem.data[15:12] == HLT_OPCODE);

    // Request whenever not halted; the address is always the current PC,
    // which only moves on an accepted response or a redirect.
    assign imem.req  = (state != HALTED);
    assign imem.addr = pc;

    // IF-side instruction seen by hazard detection in the same cycle.
    always_comb begin
        // NOTE: assigning a default before any condition gives every path a
        // value, so no latch is inferred for instr_IF.
        instr_IF = NOP_INSTR;
        if (state == FETCH && imem.valid) begin
            instr_IF = imem.data;
        end
    end

    // PC, fetch FSM and IF/ID register; priority is rst > branch > stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge, whatever the order.
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            redirect_pc  <= 16'h0000;
            instr_ID     <= NOP_INSTR;
            pc_plus2_ID  <= 16'h0000;
            valid_ID     <= 1'b0;
            fetch_halted <= 1'b0;
        end else if (branch_taken) begin
            // Squash whatever IF holds; pc_plus2_ID is meaningless under a bubble.
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
            case (state)
                FETCH: begin
                    if (imem.valid) begin
                        // Fetch completed this cycle: redirect at once.
                        pc <= branch_target;
                    end else begin
                        // Fetch still outstanding: remember target, drain it.
                        redirect_pc <= branch_target;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Newest target wins. If the stale response lands in the
                    // same cycle, the drain is over and we can go there now.
                    redirect_pc <= branch_target;
                    if (imem.valid) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    // The HLT was fetched down a wrong path; resume fetching.
                    pc           <= branch_target;
                    state        <= FETCH;
                    fetch_halted <= 1'b0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (imem.valid) begin
                            instr_ID    <= imem.data;
                            pc_plus2_ID <= pc_plus2;
                            valid_ID    <= 1'b1;
                            if (fetched_hlt) begin
                                state        <= HALTED;
                                fetch_halted <= 1'b1;
                            end else begin
                                pc <= pc_plus2;
                            end
                        end else begin
                            instr_ID <= NOP_INSTR;
                            valid_ID <= 1'b0;
                        end
                    end
                    // Stalled: everything holds; a response arriving now is
                    // dropped and re-fetched because the PC did not move.
                end
                DRAIN: begin
                    // ID already holds a bubble, so stall has nothing to hold.
                    instr_ID <= NOP_INSTR;
                    valid_ID <= 1'b0;
                    if (imem.valid) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        instr_ID <= NOP_INSTR;
                        valid_ID <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // The fetch address must stay put while a request waits for its response.
    addr_stable_a: assert property (
        @(posedge clk) disable iff (rst)
        (imem.req && !imem.valid) |=> (imem.addr == $past(imem.addr))
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/branch/reset traffic against a variable-latency instruction memory.
// A rule-level reference model produces expectations into a scoreboard queue;
// an independent monitor pops and compares them against the DUT.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instr_IF;
    logic [15:0] instr_ID;
    logic [15:0] pc_plus2_ID;
    logic        valid_ID;
    logic        fetch_halted;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .HLT_OPCODE (HLT_OPCODE),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .instr_IF      (instr_IF),
        .instr_ID      (instr_ID),
        .pc_plus2_ID   (pc_plus2_ID),
        .valid_ID      (valid_ID),
        .fetch_halted  (fetch_halted)
    );

    always #5 clk = ~clk;

    // One expected observation: outputs during a cycle, then IF/ID after its edge.
    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic [15:0] ifw;
        logic        halted;
        logic [15:0] id;
        logic [15:0] pp2;
        logic        vld;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Instruction memory image and latency control (lat_fix < 0: random 0..3).
    logic [15:0] mem [256];
    int          lat_fix = 0;
    logic        mem_active = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    int          lat_left = 0;

    // Reference model state: where fetch is, whether it has stopped on an
    // HLT, whether a redirect is waiting on an outstanding fetch, and ID.
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_drain;
    logic [15:0] m_redir;
    logic [15:0] m_id;
    logic [15:0] m_pp2;
    logic        m_vld;
    logic        known = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory answers the presented address after its chosen latency; a new
    // request starts whenever the address changes or the last one completed.
    task automatic drive_mem();
        if (imem.req !== 1'b1) begin
            mem_active = 1'b0;
            imem.valid = 1'b0;
            imem.data  = 16'($urandom);
        end else begin
            if (!mem_active || imem.addr != mem_addr) begin
                mem_active = 1'b1;
                mem_addr   = imem.addr;
                lat_left   = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
            end
            if (lat_left == 0) begin
                imem.valid = 1'b1;
                imem.data  = mem[imem.addr[8:1]];
                mem_active = 1'b0;
            end else begin
                imem.valid = 1'b0;
                imem.data  = 16'($urandom);
                lat_left--;
            end
        end
    endtask

    // Apply the per-cycle rules of the fetch stage to the model.
    task automatic model_update(input logic r, input logic s, input logic b,
                                input logic [15:0] t, input logic v, input logic [15:0] d);
        if (r) begin
            m_pc = RESET_PC; m_halted = 1'b0; m_drain = 1'b0; m_redir = 16'h0000;
            m_id = NOP_INSTR; m_pp2 = 16'h0000; m_vld = 1'b0;
        end else if (b) begin
            m_id = NOP_INSTR; m_vld = 1'b0;
            if (m_halted) begin
                m_pc = t; m_halted = 1'b0;
            end else if (m_drain) begin
                if (v) begin m_pc = t; m_drain = 1'b0; end
                else m_redir = t;
            end else if (v) begin
                m_pc = t;
            end else begin
                m_drain = 1'b1; m_redir = t;
            end
        end else if (m_drain) begin
            m_id = NOP_INSTR; m_vld = 1'b0;
            if (v) begin m_pc = m_redir; m_drain = 1'b0; end
        end else if (s) begin
            // hold everything
        end else if (m_halted) begin
            m_id = NOP_INSTR; m_vld = 1'b0;
        end else if (v) begin
            m_id = d; m_pp2 = m_pc + 16'd2; m_vld = 1'b1;
            if (d[15:12] == HLT_OPCODE) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end else begin
            m_id = NOP_INSTR; m_vld = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT should show.
    task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        drive_mem();
        #1;
        e.req    = !m_halted;
        e.addr   = m_pc;
        e.ifw    = (!m_halted && !m_drain && imem.valid) ? imem.data : NOP_INSTR;
        e.halted = m_halted;
        model_update(r, s, b, t, imem.valid, imem.data);
        e.id  = m_id;
        e.pp2 = m_pp2;
        e.vld = m_vld;
        if (known) sb_q.push_back(e);
        if (r) known = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Monitor: compare in-cycle outputs mid-cycle, IF/ID just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("imem_req",     16'(imem.req),     16'(e.req));
                check("imem_addr",    imem.addr,         e.addr);
                check("instr_IF",     instr_IF,          e.ifw);
                check("fetch_halted", 16'(fetch_halted), 16'(e.halted));
                @(posedge clk);
                #1;
                check("instr_ID",     instr_ID,          e.id);
                check("pc_plus2_ID",  pc_plus2_ID,       e.pp2);
                check("valid_ID",     16'(valid_ID),     16'(e.vld));
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        imem.valid = 1'b0; imem.data = 16'h0000;
        m_pc = RESET_PC; m_halted = 1'b0; m_drain = 1'b0; m_redir = 16'h0000;
        m_id = NOP_INSTR; m_pp2 = 16'h0000; m_vld = 1'b0;

        // Random program image with HLT kept fairly rare.
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == HLT_OPCODE && $urandom_range(0, 3) != 0) mem[i][15:12] = 4'h1;
        end
        mem[0]   = 16'h1123;
        mem[1]   = 16'h2456;
        mem[8]   = 16'hF000;   // 0x0010: HLT
        mem[16]  = 16'h4321;   // 0x0020
        mem[32]  = 16'h5040;   // 0x0040
        mem[255] = 16'h3000;   // 0xFFFE

        // Zero-wait streaming, then a 2-cycle load-use stall on 0x1123.
        lat_fix = 0;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        idle(3);

        // Three wait states per fetch.
        lat_fix = 3;
        idle(8);

        // Branch to 0x0040 while the fetch at 0x0006 is still pending.
        lat_fix = 0;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle(3);
        lat_fix = 3;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0040);
        idle(4);

        // HLT at 0x0010, then a squash back to 0x0020.
        lat_fix = 0;
        step(1'b0, 1'b0, 1'b1, 16'h0010);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0020);
        idle(2);

        // PC wrap from 0xFFFE to 0x0000.
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        idle(3);

        // Reset while draining.
        lat_fix = 3;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0080);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        idle(3);

        // Random traffic: stalls, branches (some back-to-back), rare resets.
        lat_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 12,
                 {16'($urandom_range(0, 32767)) << 1});
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 16'(sb_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
